// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes, sign fixed up after the last iteration.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q;

    logic               sign_a_d;
    logic               sign_b_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               special_d;
    logic [WIDTH-1:0]   special_res_d;

    always_comb begin
        sign_a_d = A[WIDTH-1] & ((op == OP_MULH) || (op == OP_MULHSU) ||
                                 (op == OP_DIV)  || (op == OP_REM));
        sign_b_d = B[WIDTH-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        a_mag_d  = sign_a_d ? -A : A;
        b_mag_d  = sign_b_d ? -B : B;
        special_d     = 1'b0;
        special_res_d = '0;
        // op[1] selects remainder, op[0] selects unsigned within the divide group
        if (op[2]) begin
            if (B == '0) begin
                special_d     = 1'b1;
                special_res_d = op[1] ? A : ALL_ONES;
            end else if (!op[0] && (A == MIN_NEG) && (B == ALL_ONES)) begin
                special_d     = 1'b1;
                special_res_d = op[1] ? '0 : A;
            end
        end
    end

    logic [WIDTH:0]     rem_shift;
    logic               borrow;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] step_acc_d;

    // For divide, acc_q holds {remainder, remaining dividend bits / quotient bits}
    always_comb begin
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        borrow    = rem_shift < {1'b0, opb_q};
        diff      = rem_shift[WIDTH-1:0] - opb_q;
        if (op_q[2]) begin
            if (!borrow) begin
                step_acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc_d = opb_q[0] ? (acc_q + mcand_q) : acc_q;
        end
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res_d;

    always_comb begin
        prod_fixed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo        = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       fix_res_d = prod_fixed[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_d = prod_fixed[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_res_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
            OP_REM, OP_REMU:              fix_res_d = sign_a_q ? -rem : rem;
            default:                      fix_res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        sign_a_q <= sign_a_d;
                        sign_b_q <= sign_b_d;
                        cnt_q    <= '0;
                        acc_q    <= op[2] ? {{WIDTH{1'b0}}, a_mag_d} : '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        opb_q    <= b_mag_d;
                        if (special_d) begin
                            result_q    <= special_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q   <= step_acc_d;
                    mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    opb_q   <= op_q[2] ? opb_q : {1'b0, opb_q[WIDTH-1:1]};
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised, multi-cycle integer multiply/divide unit implementing the RV32M funct3 operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable operand width. It sits beside the single-cycle ALU in the execute stage. Operands are taken through a valid/ready request handshake and results are returned through a valid/ready response handshake. An iterative shift-add / restoring-division datapath trades latency for area.

## Interface
- WIDTH, 32: operand and result width in bits; must be at least 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- in_valid  in  1  request present.
- in_ready  out  1  unit idle and able to accept a request.
- op  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  WIDTH  operand 1: multiplicand or dividend.
- B  in  WIDTH  operand 2: multiplier or divisor.
- flush  in  1  synchronous abort of any operation in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result; held stable while out_valid && !out_ready.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - FIX: sign correction and result selection.
  - DONE: out_valid=1.
- Accept happens on a rising edge with in_valid && in_ready && !flush.
  - op, A, B, signA, and signB are latched.
  - signA = A[WIDTH-1] for MULH, MULHSU, DIV, REM; otherwise 0.
  - signB = B[WIDTH-1] for MULH, DIV, REM; otherwise 0.
  - Magnitudes |A| and |B| are formed from the latched signs.
- Special cases are detected at accept. The FSM goes IDLE->DONE directly with the result loaded:
  - DIV or DIVU with B==0: quotient = all ones.
  - REM or REMU with B==0: remainder = A.
  - DIV with A==100..0 and B==all ones: quotient = A.
  - REM with A==100..0 and B==all ones: remainder = 0.
- Multiply path:
  - Uses a 2*WIDTH product register.
  - Each CALC cycle adds |A|<<i when bit i of |B| is set, LSB first.
  - The counter runs WIDTH iterations.
- Divide path:
  - Restoring division, MSB first.
  - Each cycle shifts the remainder left by 1, brings in the next dividend bit, trial-subtracts |B|, and keeps the difference when it is non-negative; the quotient bit is 1 in that case.
  - Runs WIDTH iterations.
- FIX:
  - Multiply: the product is negated when signA^signB. MUL returns product[WIDTH-1:0]; the other multiply ops return product[2W-1:W].
  - Divide: the quotient is negated when signA^signB. The remainder is negated when signA.
  - Transition FIX->DONE.
- DONE:
  - result is registered and out_valid=1.
  - On out_valid && out_ready the FSM goes to IDLE.
  - A new request is not accepted in the same cycle, because in_ready=0 in DONE.
- flush:
  - Acts in any state; the FSM goes to IDLE on the next edge.
  - out_valid deasserts and the iteration state is discarded.
  - flush beats a simultaneous accept and a simultaneous out handshake; the result is dropped.
- All arithmetic is modulo 2^WIDTH; no overflow or exception flags.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, state=IDLE, counter=0.
- rst_n assertion mid-operation clears everything immediately, without waiting for a clock edge.
- Latency, with the accept edge as cycle 0:
  - Normal ops: out_valid rises in cycle WIDTH+2 (WIDTH CALC cycles, 1 FIX cycle). That is cycle 34 for WIDTH=32.
  - Special cases: out_valid rises in cycle 1.
- in_ready is 0 from the cycle after accept until the cycle after the output handshake. Throughput is one op per WIDTH+3 cycles when out_ready is held high.
- result and out_valid are registered outputs. in_ready is decoded from state only, with no combinational path from in_valid.
- Back-pressure: DONE holds indefinitely while out_ready=0, and result does not change.

## Test plan
- Reset, then MUL A=7, B=-3 (0xFFFFFFFD), WIDTH=32, out_ready=1:
  - result=0xFFFFFFEB, out_valid exactly in cycle 34.
  - in_ready returns to 1 in cycle 35.
- High-half multiplies with A=0x80000000, B=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHU -> 0x7FFFFFFF.
  - MULHSU -> 0x80000000.
- Divide by zero with A=0x12345678, B=0:
  - DIV -> 0xFFFFFFFF, DIVU -> 0xFFFFFFFF, REM -> 0x12345678, REMU -> 0x12345678.
  - Each result valid in cycle 1.
- Signed divide edge cases:
  - DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
  - DIV A=-7, B=2 -> 0xFFFFFFFD.
  - REM A=-7, B=2 -> 0xFFFFFFFF.
- Back-pressure and flush:
  - DIVU 100/7 with out_ready=0 for 10 cycles -> result=14 held stable and out_valid held.
  - New in_valid is ignored (in_ready=0) during that window.
  - flush asserted in cycle 5 of another op -> out_valid never rises, in_ready=1 in the next cycle.
- Async reset in cycle 10 of a MULHU -> outputs return to reset values before the next edge. A following request completes correctly. Repeat the whole suite with WIDTH=8 against a reference model.
